id_scoreboard_stage: RTL
========================

# id_scoreboard_stage

Parametrised IF→ID pipeline register with a register-write scoreboard. It generalises the fixed EXE/MEM/WB destination compare to any number of in-flight writers. It latches the IF→ID bus under a valid/allow-in handshake and tracks outstanding writes per architectural register with saturating counters. It stalls issue to EXE on RAW hazards and releases registers when WB retires them. It sits between `fetch` and `decode` and drives `ID_valid` and `ID_over` for the rest of the pipeline.

## Interface
Parameters:
- `BUS_W`, 64, width of the IF→ID bus ({pc, inst}).
- `NREG`, 32, number of architectural registers; register 0 is never tracked.
- `CNT_W`, 2, scoreboard counter width; max outstanding writes per register = 2^CNT_W−1.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `IF_over` in 1: IF presents a valid bus this cycle.
- `IF_ID_bus` in BUS_W: instruction bus from IF.
- `ID_allow_in` out 1: stage can accept a new bus this cycle.
- `ID_valid` out 1: held instruction is valid.
- `IF_ID_bus_r` out BUS_W: held bus, to `decode`.
- `rs`, `rt` in log2(NREG): source register numbers from `decode`.
- `rs_used`, `rt_used` in 1: the instruction reads `rs` / `rt`.
- `dest_wen` in 1: the instruction writes a register.
- `dest` in log2(NREG): destination register number.
- `EXE_allow_in` in 1: EXE accepts this cycle.
- `ID_over` out 1: the held instruction issues to EXE this cycle.
- `WB_retire` in 1: a tracked write completes this cycle.
- `WB_wdest` in log2(NREG): register retired.
- `flush` in 1: cancel the held instruction.
- `hazard` out 1: issue is blocked by the scoreboard.
- `sb_err` out 1: sticky flag, set on retire of an untracked register.
- `stall_cnt` out 32: hazard-stall cycle count (see Configuration).

## Operation
- Scoreboard: `cnt[r]` for r = 1..NREG−1. `cnt[0]` reads as 0 and is never written.
- RAW/structural hazard:
  - `hazard = ID_valid & ~flush & (src_busy | dst_full)`.
  - `src_busy = (rs_used & rs≠0 & cnt[rs]≠0) | (rt_used & rt≠0 & cnt[rt]≠0)`.
  - `dst_full = dest_wen & dest≠0 & cnt[dest]==2^CNT_W−1`.
  - WAW is not a hazard: issue is in order.
- Hazard evaluation uses the registered counters only. A retire becomes visible the cycle after `WB_retire`; there is no same-cycle bypass.
- `ID_over = ID_valid & ~hazard & EXE_allow_in & ~flush`.
- `ID_allow_in = ~ID_valid | ID_over`.
- Load: when `IF_over & ID_allow_in & ~flush`, `IF_ID_bus_r <= IF_ID_bus` and `ID_valid <= 1`.
- Otherwise, `ID_over` or `flush` clears `ID_valid`. The bus register holds its value when not loaded.
- Counter update:
  - +1 on `ID_over & dest_wen & dest≠0`.
  - −1 on `WB_retire & WB_wdest≠0`.
  - Both on the same register in one cycle: net unchanged.
- A retire with `cnt[WB_wdest]==0` leaves the counter at 0 and sets `sb_err`. `sb_err` clears only on reset.
- `flush` drops the held instruction and blocks that cycle's load. It does not clear the scoreboard, because in-flight writes still retire.

## Timing
- Reset values: `ID_valid` 0, `IF_ID_bus_r` 0, all counters 0, `sb_err` 0, `stall_cnt` 0. `ID_allow_in` reads 1 after reset.
- Latency IF→ID is 1 cycle. An instruction loaded at edge N can issue in the cycle following edge N (`ID_over` combinational).
- Back-to-back throughput is 1/cycle when hazard-free: load and issue in the same cycle are allowed.
- Producer→consumer minimum gap: the consumer issues no earlier than the cycle after the producer's `WB_retire`.
- Reset asserted mid-stall clears all state at that edge and overrides every other input.

## Configuration
- `ID_SB_PERF_EN` defined:
  - `stall_cnt` increments each cycle `hazard` is 1.
  - It wraps modulo 2^32 and resets to 0.
- `ID_SB_PERF_EN` undefined:
  - No counter is built.
  - The `stall_cnt` port remains and is constant 0.

## Test plan
- Reset held 2 cycles, then `IF_OVER=1` with bus 0x00000034_02A15020 → `ID_valid`=1 next cycle, `IF_ID_bus_r` matches, `ID_over`=1 with `EXE_allow_in`=1.
- Issue dest=2, then a consumer with rs=2 → `hazard`=1, `ID_allow_in`=0. `WB_retire` of r2 → consumer `ID_over`=1 exactly one cycle later. With the macro defined, `stall_cnt` equals the stalled cycles.
- CNT_W=2: issue three writes to r5 with no retire; a fourth write to r5 → `hazard`=1 (dst_full). One retire of r5 → the fourth issues next cycle and `cnt[5]`=3.
- Same cycle: `ID_over` with dest=7 and `WB_retire` of r7 while `cnt[7]`=1 → `cnt[7]` stays 1.
- `WB_retire` of r9 while `cnt[9]`=0 → `sb_err`=1 and stays set. A write to r0 → no counter change and no hazard on later rs=0 reads.
- `flush` while stalled with `IF_over`=1 → `ID_valid`=0 next cycle, no load, `ID_over`=0, scoreboard unchanged.

Source files
------------

// File: rtl/id_scoreboard_stage.sv
// id_scoreboard_stage: IF->ID pipeline register with a per-register write scoreboard.
// Optional feature macro: ID_SB_PERF_EN builds the hazard-stall cycle counter.
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   IF_over, IF_ID_bus           incoming bus from fetch and its valid
//   ID_allow_in, ID_valid        handshake toward fetch, held-instruction valid
//   IF_ID_bus_r                  held bus toward decode
//   rs/rt(_used), dest(_wen)     register usage of the held instruction
//   EXE_allow_in, ID_over        issue handshake toward EXE
//   WB_retire, WB_wdest          write completions from WB
//   flush                        cancels the held instruction
//   hazard, sb_err, stall_cnt    stall flag, sticky retire error, stall counter
module id_scoreboard_stage #(
   parameter int BUS_W = 64,
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     IF_over,
   input  logic [BUS_W-1:0]         IF_ID_bus,
   output logic                     ID_allow_in,
   output logic                     ID_valid,
   output logic [BUS_W-1:0]         IF_ID_bus_r,
   input  logic [$clog2(NREG)-1:0]  rs,
   input  logic [$clog2(NREG)-1:0]  rt,
   input  logic                     rs_used,
   input  logic                     rt_used,
   input  logic                     dest_wen,
   input  logic [$clog2(NREG)-1:0]  dest,
   input  logic                     EXE_allow_in,
   output logic                     ID_over,
   input  logic                     WB_retire,
   input  logic [$clog2(NREG)-1:0]  WB_wdest,
   input  logic                     flush,
   output logic                     hazard,
   output logic                     sb_err,
   output logic [31:0]              stall_cnt
);
   localparam int AW = $clog2(NREG);
   logic              r_valid;
   logic [BUS_W-1:0]  r_bus;
   logic [CNT_W-1:0]  r_cnt [1:NREG-1];
   logic              r_sb_err;
   logic              w_src_busy;
   logic              w_dst_full;
   logic              w_load;
   logic              w_wb_err;
   // register 0 is never tracked and always reads as idle
   function automatic logic [CNT_W-1:0] f_cnt(input logic [AW-1:0] a);
      return (a == '0) ? '0 : r_cnt[a];
   endfunction
   assign w_src_busy  = (rs_used & (f_cnt(rs) != '0)) | (rt_used & (f_cnt(rt) != '0));
   assign w_dst_full  = dest_wen & (f_cnt(dest) == '1);
   assign hazard      = r_valid & ~flush & (w_src_busy | w_dst_full);
   assign ID_over     = r_valid & ~hazard & EXE_allow_in & ~flush;
   assign ID_allow_in = ~r_valid | ID_over;
   assign w_load      = IF_over & ID_allow_in & ~flush;
   assign w_wb_err    = WB_retire & (WB_wdest != '0) & (f_cnt(WB_wdest) == '0);
   assign ID_valid    = r_valid;
   assign IF_ID_bus_r = r_bus;
   assign sb_err      = r_sb_err;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_bus   <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_bus   <= IF_ID_bus;
      end else if (ID_over | flush) begin
         r_valid <= 1'b0;
      end
   end
   // an issue and a retire of the same register cancel out; a retire at 0 stays at 0
   always_ff @(posedge clk) begin
      for (int i = 1; i < NREG; i++) begin
         if (reset)
            r_cnt[i] <= '0;
         else if ((ID_over & dest_wen & (dest == AW'(i))) & ~(WB_retire & (WB_wdest == AW'(i))))
            r_cnt[i] <= r_cnt[i] + 1'b1;
         else if ((WB_retire & (WB_wdest == AW'(i))) & ~(ID_over & dest_wen & (dest == AW'(i))) & (r_cnt[i] != '0))
            r_cnt[i] <= r_cnt[i] - 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset)
         r_sb_err <= 1'b0;
      else if (w_wb_err)
         r_sb_err <= 1'b1;
   end
`ifdef ID_SB_PERF_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk) begin
      if (reset)
         r_stall <= '0;
      else if (hazard)
         r_stall <= r_stall + 32'd1;
   end
   assign stall_cnt = r_stall;
`else
   assign stall_cnt = '0;
`endif
endmodule
